// File: rtl/fp32_sub_seq.sv
// Multi-cycle IEEE-754 binary32 subtractor (res = a - b) with 1-bit/cycle align and normalise, RNE rounding.
// Optional build macro FP32_SUB_FTZ_EN: denormal inputs and results are flushed to signed zero.
module fp32_sub_seq #(
    parameter int ALIGN_MAX = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        busy
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, and out_valid/res hold steady until out_ready is seen.
    localparam logic [7:0]  ALIGN_CAP = 8'(ALIGN_MAX);
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        sx_q, sx_d, sy_q, sy_d;
    logic [9:0]  ex_q, ex_d;
    logic [27:0] mx_q, mx_d, my_q, my_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [7:0]  ea, eb, xe_eff, ye_eff, exp_diff;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, swap, special;
    logic [31:0] x_op, y_op, special_res;
    logic [27:0] sum;
    logic        round_up;
    logic [24:0] rnd_mant;
    logic [9:0]  rnd_exp;
    logic [31:0] rnd_res;

    // Operand classification; b_q already carries the flipped sign.
    always_comb begin
        ea    = a_q[30:23];
        eb    = b_q[30:23];
        fa    = a_q[22:0];
        fb    = b_q[22:0];
        a_nan = (ea == 8'hFF) && (fa != '0);
        b_nan = (eb == 8'hFF) && (fb != '0);
        a_inf = (ea == 8'hFF) && (fa == '0);
        b_inf = (eb == 8'hFF) && (fb == '0);
`ifdef FP32_SUB_FTZ_EN
        if (ea == 8'h00) fa = '0;
        if (eb == 8'h00) fb = '0;
`endif
        swap     = b_q[30:0] > a_q[30:0];
        x_op     = swap ? {b_q[31], eb, fb} : {a_q[31], ea, fa};
        y_op     = swap ? {a_q[31], ea, fa} : {b_q[31], eb, fb};
        xe_eff   = (x_op[30:23] == 8'h00) ? 8'd1 : x_op[30:23];
        ye_eff   = (y_op[30:23] == 8'h00) ? 8'd1 : y_op[30:23];
        exp_diff = xe_eff - ye_eff;

        special     = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan)     special_res = QNAN;
        else if (a_inf && b_inf) special_res = (a_q[31] != b_q[31]) ? QNAN : {a_q[31], 8'hFF, 23'h0};
        else if (a_inf)          special_res = {a_q[31], 8'hFF, 23'h0};
        else if (b_inf)          special_res = {b_q[31], 8'hFF, 23'h0};
        else                     special = 1'b0;
    end

    // Rounding on {hidden, frac} with G/R/S in the low three bits.
    always_comb begin
        round_up = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
        rnd_mant = {1'b0, mx_q[26:3]} + {24'h0, round_up};
        rnd_exp  = ex_q + {9'h0, rnd_mant[24]};
        if (rnd_exp >= 10'd255)  rnd_res = {sx_q, 8'hFF, 23'h0};
        else if (rnd_mant[24])   rnd_res = {sx_q, rnd_exp[7:0], 23'h0};
        else if (rnd_mant[23])   rnd_res = {sx_q, rnd_exp[7:0], rnd_mant[22:0]};
        else begin
`ifdef FP32_SUB_FTZ_EN
            rnd_res = {sx_q, 31'h0};
`else
            rnd_res = {sx_q, 8'h00, rnd_mant[22:0]};
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ex_d    = ex_q;
        mx_d    = mx_q;
        my_d    = my_q;
        cnt_d   = cnt_q;
        sum     = (sx_q == sy_q) ? (mx_q + my_q) : (mx_q - my_q);
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {~b[31], b[30:0]};
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (special) begin
                    res_d   = special_res;
                    state_d = S_DONE;
                end else begin
                    sx_d    = x_op[31];
                    sy_d    = y_op[31];
                    ex_d    = {2'b00, xe_eff};
                    mx_d    = {1'b0, x_op[30:23] != 8'h00, x_op[22:0], 3'b000};
                    my_d    = {1'b0, y_op[30:23] != 8'h00, y_op[22:0], 3'b000};
                    cnt_d   = (exp_diff > ALIGN_CAP) ? ALIGN_CAP : exp_diff;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (cnt_q != 8'd0) begin
                    my_d  = {1'b0, my_q[27:2], my_q[1] | my_q[0]};
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // Exact zero: -0 only when both addends were -0, otherwise +0.
                if (sum == '0) begin
                    mx_d = '0;
                    ex_d = 10'd1;
                    sx_d = (sx_q == sy_q) ? sx_q : 1'b0;
                end else begin
                    mx_d = sum;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (mx_q[27]) begin
                    mx_d = {1'b0, mx_q[27:2], mx_q[1] | mx_q[0]};
                    ex_d = ex_q + 10'd1;
                end else if (!mx_q[26] && (ex_q > 10'd1)) begin
                    mx_d = {mx_q[26:0], 1'b0};
                    ex_d = ex_q - 10'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                res_d   = rnd_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ex_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ex_q    <= ex_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res       = res_q;
endmodule
